cpc_ram_bank_ctrl: RTL and testbench

//  Bus responder inside the XC9572 CPLD on the 512K CPC RAM expansion board.
//  - Snoops Z80 I/O writes to the Gate Array RAM port (A15=0, A14=1, D[7:6]=11).
//  - Holds the bank/configuration register.
//  - Per memory cycle, decides whether the external 512K SRAM or the CPC

---
 rtl/cpc_ram_bank_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cpc_ram_bank_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpc_ram_bank_ctrl.sv
// ----------------------------------------------------------------------------
// cpc_ram_bank_ctrl
//
// Bus responder for the 512K CPC RAM expansion board (XC9572 CPLD).
// It snoops Z80 OUT writes to the Gate Array RAM port (A15=0, A14=1,
// D[7:6]=11) and keeps the bank/configuration register. For every memory
// cycle it decides whether the external 512K SRAM or the CPC internal RAM
// answers.
//
// Optional feature macro: CPC_RAM_MREQ_LATCH_EN
//   When defined, sel/page/bank are captured on the first CLK rising edge
//   with MREQ_B low and held until MREQ_B returns high. When undefined, the
//   mapping is fully combinational with zero latency.
//
// Parameters
//   CFG_RESET   config field value after reset
//   BANK_RESET  bank field value after reset
//
// Ports
//   CLK       in  Z80 clock
//   RESET_B   in  asynchronous active-low reset
//   A15, A14  in  Z80 address bits / memory block select
//   D[7:0]    in  Z80 data bus (sampled only)
//   IOREQ_B   in  Z80 I/O request
//   MREQ_B    in  Z80 memory request
//   M1_B      in  Z80 M1 (low with IOREQ_B = interrupt acknowledge)
//   RFSH_B    in  Z80 refresh (low = no SRAM access)
//   WR_B      in  Z80 write strobe
//   RAMRD_B   in  CPC RAM read strobe
//   dip0      in  1 = expansion disabled
//   dip1      in  1 = 6128 host, ext bank 0 left to internal RAM
//   HIADR     out SRAM A18..A14 = {bank, page[1:0]}
//   RAMDIS    out 1 = disable CPC internal RAM this cycle
//   RAMCS_B   out SRAM chip select
//   RAMWE_B   out SRAM write enable
//   RAMOE_B   out SRAM output enable
// ----------------------------------------------------------------------------
module cpc_ram_bank_ctrl #(
  parameter logic [2:0] CFG_RESET  = 3'd0,
  parameter logic [2:0] BANK_RESET = 3'd0
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       A15,
  input  logic       A14,
  input  logic [7:0] D,
  input  logic       IOREQ_B,
  input  logic       MREQ_B,
  input  logic       M1_B,
  input  logic       RFSH_B,
  input  logic       WR_B,
  input  logic       RAMRD_B,
  input  logic       dip0,
  input  logic       dip1,
  output logic [4:0] HIADR,
  output logic       RAMDIS,
  output logic       RAMCS_B,
  output logic       RAMWE_B,
  output logic       RAMOE_B
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_WAIT  = 2'd2
  } cap_state_t;

  cap_state_t state, next_state;
  logic [2:0] cfg, bank;
  logic       load;
  logic [1:0] block;
  logic [2:0] page;
  logic       sel_comb;
  logic       sel_eff;
  logic [2:0] page_eff;
  logic [2:0] bank_eff;

  assign block = {A15, A14};

  // Capture FSM: a matching Gate Array RAM write loads the register once,
  // then the FSM parks in WAIT until IOREQ_B deasserts, so wait states
  // stretching the OUT cycle cannot cause a second load.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!IOREQ_B && !WR_B && M1_B && !A15 && A14 && (D[7:6] == 2'b11)) begin
          next_state = S_LATCH;
          load       = 1'b1;
        end
      end
      S_LATCH: next_state = S_WAIT;
      S_WAIT: begin
        if (IOREQ_B) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state <= S_IDLE;
      cfg   <= CFG_RESET;
      bank  <= BANK_RESET;
    end else begin
      state <= next_state;
      if (load) begin
        cfg  <= D[2:0];
        bank <= D[5:3];
      end
    end
  end

  // Page map: pages 0-3 are internal, 4-7 external. C4..C7 only remap
  // block 1, to page 4..7 respectively (the cfg value itself).
  always_comb begin
    page = {1'b0, block};
    case (cfg)
      3'd0: page = {1'b0, block};
      3'd1: page = (block == 2'd3) ? 3'd7 : {1'b0, block};
      3'd2: page = {1'b1, block};
      3'd3: begin
        case (block)
          2'd0:    page = 3'd0;
          2'd1:    page = 3'd3;
          2'd2:    page = 3'd2;
          default: page = 3'd7;
        endcase
      end
      default: page = (block == 2'd1) ? cfg : {1'b0, block};
    endcase
  end

  assign sel_comb = page[2] & ~dip0 & ~(dip1 & (bank == 3'd0));

`ifdef CPC_RAM_MREQ_LATCH_EN
  logic       held;
  logic       sel_q;
  logic [2:0] page_q, bank_q;

  // Freeze the decode on the first edge of each memory cycle so late
  // settling address lines cannot glitch the SRAM strobes. Until that edge
  // the expansion stays deselected.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      held   <= 1'b0;
      sel_q  <= 1'b0;
      page_q <= 3'd0;
      bank_q <= 3'd0;
    end else if (MREQ_B) begin
      held <= 1'b0;
    end else if (!held) begin
      held   <= 1'b1;
      sel_q  <= sel_comb;
      page_q <= page;
      bank_q <= bank;
    end
  end

  assign sel_eff  = held & ~MREQ_B & sel_q & RESET_B;
  assign page_eff = page_q;
  assign bank_eff = bank_q;
`else
  assign sel_eff  = sel_comb & RESET_B;
  assign page_eff = page;
  assign bank_eff = bank;
`endif

  // Reset also forces every output inactive, whatever CFG_RESET is.
  assign RAMDIS  = sel_eff;
  assign HIADR   = sel_eff ? {bank_eff, page_eff[1:0]} : 5'd0;
  assign RAMCS_B = ~(sel_eff & ~MREQ_B & RFSH_B);
  assign RAMWE_B = RAMCS_B | WR_B;
  assign RAMOE_B = RAMCS_B | RAMRD_B;

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpc_ram_bank_ctrl
//
// Self-checking bench for cpc_ram_bank_ctrl (default build). A reference
// model of the bank register and page table predicts the output vector
// {HIADR, RAMDIS, RAMCS_B, RAMWE_B, RAMOE_B} for each memory access; the
// prediction is queued when the access is driven and popped when the DUT
// outputs are sampled.
// ----------------------------------------------------------------------------
module tb_cpc_ram_bank_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       A15, A14;
  logic [7:0] D;
  logic       IOREQ_B, MREQ_B, M1_B, RFSH_B, WR_B, RAMRD_B;
  logic       dip0, dip1;
  logic [4:0] HIADR;
  logic       RAMDIS, RAMCS_B, RAMWE_B, RAMOE_B;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [2:0] m_cfg  = 3'd0;
  logic [2:0] m_bank = 3'd0;
  logic       m_rst  = 1'b0;

  logic [2:0] page_tbl [8][4] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd0, 3'd1, 3'd2, 3'd7},
    '{3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd0, 3'd3, 3'd2, 3'd7},
    '{3'd0, 3'd4, 3'd2, 3'd3},
    '{3'd0, 3'd5, 3'd2, 3'd3},
    '{3'd0, 3'd6, 3'd2, 3'd3},
    '{3'd0, 3'd7, 3'd2, 3'd3}
  };

  logic [8:0] exp_q [$];
  string      tag_q [$];

  cpc_ram_bank_ctrl dut (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .A15     (A15),
    .A14     (A14),
    .D       (D),
    .IOREQ_B (IOREQ_B),
    .MREQ_B  (MREQ_B),
    .M1_B    (M1_B),
    .RFSH_B  (RFSH_B),
    .WR_B    (WR_B),
    .RAMRD_B (RAMRD_B),
    .dip0    (dip0),
    .dip1    (dip1),
    .HIADR   (HIADR),
    .RAMDIS  (RAMDIS),
    .RAMCS_B (RAMCS_B),
    .RAMWE_B (RAMWE_B),
    .RAMOE_B (RAMOE_B)
  );

  // 10 ns Z80 clock
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s got={hiadr,dis,cs,we,oe}=%b expected=%b", tag, got, expv);
    end
  endtask

  // Model prediction for a memory access with MREQ_B low.
  function automatic logic [8:0] modelOut(input logic [1:0] blk, input logic wr, input logic rd,
                                          input logic rfsh);
    logic [2:0] pg;
    logic       sel, cs, we, oe;
    logic [4:0] hi;
    pg  = page_tbl[m_cfg][blk];
    sel = m_rst && (pg >= 3'd4) && !dip0 && !(dip1 && (m_bank == 3'd0));
    cs  = !(sel && rfsh);
    we  = cs || wr;
    oe  = cs || rd;
    hi  = sel ? {m_bank, pg[1:0]} : 5'd0;
    return {hi, sel, cs, we, oe};
  endfunction

  // Drive one memory access, queue the prediction, then sample away from
  // the clock edge and compare against the oldest queued prediction.
  task automatic applyStimulus(input string tag, input logic [1:0] blk, input logic wr,
                               input logic rd, input logic rfsh);
    @(negedge CLK);
    IOREQ_B = 1'b1;
    M1_B    = 1'b1;
    {A15, A14} = blk;
    WR_B    = wr;
    RAMRD_B = rd;
    RFSH_B  = rfsh;
    MREQ_B  = 1'b0;
    exp_q.push_back(modelOut(blk, wr, rd, rfsh));
    tag_q.push_back(tag);
    #2;
    checkOutput(tag_q.pop_front(), {HIADR, RAMDIS, RAMCS_B, RAMWE_B, RAMOE_B}, exp_q.pop_front());
    MREQ_B  = 1'b1;
    WR_B    = 1'b1;
    RAMRD_B = 1'b1;
    RFSH_B  = 1'b1;
  endtask

  // OUT &7F00,data held for 'hold' clocks; D switches to data2 after the
  // first edge. Only the value present on that first edge may be taken.
  task automatic ioWrite(input logic [7:0] data, input logic [7:0] data2, input logic m1,
                         input int hold);
    @(negedge CLK);
    MREQ_B  = 1'b1;
    A15     = 1'b0;
    A14     = 1'b1;
    D       = data;
    M1_B    = m1;
    WR_B    = 1'b0;
    IOREQ_B = 1'b0;
    if (data[7:6] == 2'b11 && m1 && m_rst) begin
      m_cfg  = data[2:0];
      m_bank = data[5:3];
    end
    @(negedge CLK);
    D = data2;
    for (int i = 1; i < hold; i++) @(negedge CLK);
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
    M1_B    = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RESET_B = 1'b0;
    A15 = 1'b0; A14 = 1'b0; D = 8'h00;
    IOREQ_B = 1'b1; MREQ_B = 1'b1; M1_B = 1'b1; RFSH_B = 1'b1;
    WR_B = 1'b1; RAMRD_B = 1'b1; dip0 = 1'b0; dip1 = 1'b0;

    // 1: reset state and C0 after reset
    applyStimulus("in_reset_blk3", 2'd3, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    RESET_B = 1'b1;
    m_rst   = 1'b1;
    applyStimulus("c0_blk3_read", 2'd3, 1'b1, 1'b0, 1'b1);

    // 2: C2 bank 0, expansion answers block 1; RAMOE_B follows RAMRD_B
    ioWrite(8'hC2, 8'hC2, 1'b1, 1);
    applyStimulus("c2_blk1_rd", 2'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus("c2_blk1_nord", 2'd1, 1'b1, 1'b1, 1'b1);

    // 3: bank 7 C7, write at 0x4000, then 0xC000 internal
    ioWrite(8'hFF, 8'hFF, 1'b1, 1);
    applyStimulus("c7_blk1_wr", 2'd1, 1'b0, 1'b1, 1'b1);
    applyStimulus("c7_blk3", 2'd3, 1'b1, 1'b0, 1'b1);

    // 4: 6128 host, bank 0 left internal; bank 1 answers
    dip1 = 1'b1;
    ioWrite(8'hC1, 8'hC1, 1'b1, 1);
    for (int b = 0; b < 4; b++) applyStimulus("dip1_bank0", b[1:0], 1'b1, 1'b0, 1'b1);
    ioWrite(8'hC9, 8'hC9, 1'b1, 1);
    applyStimulus("c1_bank1_blk3", 2'd3, 1'b1, 1'b0, 1'b1);

    // 5: non-RAM writes and INT ack leave cfg/bank untouched
    ioWrite(8'h82, 8'h82, 1'b1, 1);
    ioWrite(8'h42, 8'h42, 1'b1, 1);
    ioWrite(8'hC2, 8'hC2, 1'b0, 1);
    for (int b = 0; b < 4; b++) applyStimulus("ignored_wr", b[1:0], 1'b1, 1'b0, 1'b1);

    // 6: stretched OUT with D changing after the first edge
    dip1 = 1'b0;
    ioWrite(8'hC2, 8'hC4, 1'b1, 4);
    applyStimulus("stretch_blk0", 2'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus("stretch_blk1", 2'd1, 1'b0, 1'b1, 1'b1);

    // 6: reset pulsed in the middle of an OUT cycle
    @(negedge CLK);
    A15 = 1'b0; A14 = 1'b1; D = 8'hC5; WR_B = 1'b0; IOREQ_B = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_B = 1'b0;
    m_rst   = 1'b0;
    m_cfg   = 3'd0;
    m_bank  = 3'd0;
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
    applyStimulus("midcyc_reset", 2'd1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    RESET_B = 1'b1;
    m_rst   = 1'b1;
    for (int b = 0; b < 4; b++) applyStimulus("after_reset", b[1:0], 1'b1, 1'b0, 1'b1);

    // dip0 disables the board; refresh blocks the SRAM strobes only
    ioWrite(8'hC2, 8'hC2, 1'b1, 1);
    dip0 = 1'b1;
    applyStimulus("dip0_off", 2'd2, 1'b1, 1'b0, 1'b1);
    dip0 = 1'b0;
    applyStimulus("rfsh_blk2", 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus("c2_blk2_rd", 2'd2, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
